sccb_write_master: RTL and testbench

SCCB_WRITE_MASTER -- requirements
Module: sccb_write_master

---
 rtl/sccb_write_master.sv | 118 +++++++++++
 tb/tb_sccb_write_master.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_write_master.sv
// SCCB/I2C 3-phase write master: START, 4 bytes (dev, reg hi, reg lo, data) each with ACK slot, STOP.
// Optional macro SCCB_NACK_CHK_EN enables ACK sampling, a sticky nack_err and early STOP on NACK.
module sccb_write_master #(
    parameter int unsigned CLK_DIV = 250
) (
    input  logic        clk_100,
    input  logic        rst_100,
    input  logic [31:0] cfg_data,
    input  logic        i2c_req,
    output logic        i2c_ack,
    output logic        busy,
    output logic        nack_err,
    output logic        sclk,
    inout  logic        sda
);

    localparam int unsigned QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {IDLE, START, SHIFT, ACKBIT, STOP, DONE} state_t;

    state_t        state, state_nxt;
    logic [QW-1:0] qcnt;
    logic [1:0]    qtr;
    logic [2:0]    bit_cnt;
    logic [1:0]    byte_cnt;
    logic [31:0]   shreg;
    logic          sda_oe;
    logic          q_end;
    logic          bit_end;
    logic          accept;

    assign q_end   = (qcnt == QW'(CLK_DIV - 1));
    assign bit_end = q_end && (qtr == 2'd3);
    assign accept  = (state == IDLE) && i2c_req;

    always_ff @(posedge clk_100) begin
        if (rst_100) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (i2c_req) state_nxt = START;
            START:  if (bit_end) state_nxt = SHIFT;
            SHIFT:  if (bit_end && bit_cnt == 3'd7) state_nxt = ACKBIT;
            // nack_err can only be set in this ACK slot, so it doubles as the abort flag
            ACKBIT: if (bit_end) state_nxt = (byte_cnt == 2'd3 || nack_err) ? STOP : SHIFT;
            STOP:   if (bit_end) state_nxt = DONE;
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_100) begin
        if (rst_100) begin
            qcnt     <= '0;
            qtr      <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            shreg    <= '0;
        end else if (accept) begin
            shreg    <= cfg_data;
            qcnt     <= '0;
            qtr      <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
        end else if (state != IDLE && state != DONE) begin
            qcnt <= q_end ? '0 : qcnt + 1'b1;
            if (q_end) qtr <= qtr + 2'd1;
            if (bit_end && state == SHIFT) begin
                shreg   <= {shreg[30:0], 1'b0};
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (bit_end && state == ACKBIT && byte_cnt != 2'd3)
                byte_cnt <= byte_cnt + 2'd1;
        end
    end

`ifdef SCCB_NACK_CHK_EN
    always_ff @(posedge clk_100) begin
        if (rst_100 || accept)
            nack_err <= 1'b0;
        else if (state == ACKBIT && qtr == 2'd2 && q_end && sda)
            nack_err <= 1'b1;
    end
`else
    assign nack_err = 1'b0;
`endif

    always_comb begin
        sclk    = 1'b1;
        sda_oe  = 1'b0;
        i2c_ack = 1'b0;
        busy    = 1'b1;
        case (state)
            IDLE:   busy = 1'b0;
            START: begin
                sda_oe = (qtr >= 2'd2);
                sclk   = (qtr != 2'd3);
            end
            SHIFT: begin
                sda_oe = ~shreg[31];
                sclk   = (qtr == 2'd1) || (qtr == 2'd2);
            end
            ACKBIT: sclk = (qtr == 2'd1) || (qtr == 2'd2);
            STOP: begin
                sda_oe = (qtr <= 2'd1);
                sclk   = (qtr != 2'd0);
            end
            DONE:   i2c_ack = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    assign sda = sda_oe ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_sccb_write_master.sv
// Scoreboard bench for sccb_write_master at CLK_DIV=4; a bus decoder/slave model rebuilds bytes from SCL/SDA.
// Expectations follow SCCB_NACK_CHK_EN when the bench is built with the same macro.
module tb_sccb_write_master;

    localparam int unsigned DIV  = 4;
    localparam int          LAT4 = 152 * 4 + 1;
`ifdef SCCB_NACK_CHK_EN
    localparam int          NACK_NB  = 1;
    localparam int          NACK_LAT = 9 * 16 + 4 * 4 + 4 * 4 + 1;
    localparam bit          NACK_FLG = 1'b1;
`else
    localparam int          NACK_NB  = 4;
    localparam int          NACK_LAT = LAT4;
    localparam bit          NACK_FLG = 1'b0;
`endif

    logic        clk_100 = 1'b0;
    logic        rst_100 = 1'b1;
    logic [31:0] cfg_data = '0;
    logic        i2c_req = 1'b0;
    logic        i2c_ack, busy, nack_err, sclk;
    wire         sda;
    logic        slave_drv = 1'b0;
    bit          slave_ack = 1'b1;

    pullup (sda);
    assign sda = slave_drv ? 1'b0 : 1'bz;

    sccb_write_master #(.CLK_DIV(DIV)) dut (
        .clk_100 (clk_100),
        .rst_100 (rst_100),
        .cfg_data(cfg_data),
        .i2c_req (i2c_req),
        .i2c_ack (i2c_ack),
        .busy    (busy),
        .nack_err(nack_err),
        .sclk    (sclk),
        .sda     (sda)
    );

    always #5 clk_100 = ~clk_100;

    int cyc = 0;
    always @(posedge clk_100) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        int          nbytes;
        int          acc;
        int          lat;
        bit          nack;
    } exp_t;

    // kind 0: line/status snapshot, 1: bounded wait outcome, 2: scoreboard drained
    typedef struct {
        string name;
        int    kind;
        bit    scl, sdav, bsy, ack, nck, ok;
    } probe_t;

    exp_t   sb[$];
    probe_t pq[$];
    int     errors = 0;
    int     checks = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: bus decoder + slave ACK driver + scoreboard/probe checker
    logic [7:0] rx[$];
    logic [7:0] cur = '0;
    int         bitn = 0;
    bit         in_txn = 0, stop_seen = 0;
    logic       scl_p = 1'b1, sda_p = 1'b1;

    initial begin
        exp_t       e;
        probe_t     p;
        logic       s, c;
        logic [31:0] d;
        forever begin
            @(negedge clk_100);
            s = sda;
            c = sclk;
            if (rst_100) begin
                in_txn    = 0;
                slave_drv = 1'b0;
            end else begin
                if (c && scl_p && sda_p && !s) begin
                    in_txn = 1; bitn = 0; rx.delete(); stop_seen = 0;
                end else if (in_txn && c && scl_p && !sda_p && s) begin
                    stop_seen = 1; in_txn = 0;
                end
                if (in_txn && c && !scl_p) begin
                    if (bitn < 8) cur = {cur[6:0], s};
                    bitn++;
                    if (bitn == 8) rx.push_back(cur);
                    if (bitn == 9) bitn = 0;
                end
                if (in_txn && !c && scl_p) slave_drv = (bitn == 8) && slave_ack;
            end
            scl_p = c;
            sda_p = s;

            if (i2c_ack === 1'b1) begin
                if (sb.size() == 0) chk("spurious_ack", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("ack_latency", cyc - e.acc, e.lat);
                    chk("nack_err_at_ack", int'(nack_err), int'(e.nack));
                    chk("stop_seen", int'(stop_seen), 1);
                    chk("byte_count", rx.size(), e.nbytes);
                    d = e.data;
                    for (int k = 0; k < e.nbytes && k < rx.size(); k++)
                        chk($sformatf("byte%0d", k), int'(rx[k]), int'(d[31 - 8 * k -: 8]));
                end
            end

            while (pq.size() > 0) begin
                p = pq.pop_front();
                case (p.kind)
                    0: begin
                        chk({p.name, "_sclk"}, int'(sclk), int'(p.scl));
                        chk({p.name, "_sda"},  int'(s),    int'(p.sdav));
                        chk({p.name, "_busy"}, int'(busy), int'(p.bsy));
                        chk({p.name, "_ack"},  int'(i2c_ack), int'(p.ack));
                        chk({p.name, "_nack"}, int'(nack_err), int'(p.nck));
                    end
                    1: chk(p.name, int'(p.ok), 1);
                    default: chk(p.name, sb.size(), 0);
                endcase
            end
        end
    end

    task automatic probe(input string nm, input bit scl, input bit sdav, input bit bsy,
                         input bit ack, input bit nck);
        pq.push_back('{nm, 0, scl, sdav, bsy, ack, nck, 1'b0});
    endtask

    task automatic issue(input logic [31:0] d, input int nb, input int lat, input bit nk,
                         input bit push);
        @(posedge clk_100); #1;
        cfg_data = d;
        i2c_req  = 1'b1;
        if (push) sb.push_back('{d, nb, cyc, lat, nk});
        @(posedge clk_100); #1;
        i2c_req = 1'b0;
        probe("accept", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic wait_ack(input string nm);
        bit seen = 0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk_100);
            if (i2c_ack === 1'b1) seen = 1;
        end
        pq.push_back('{nm, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, seen});
    endtask

    initial begin
        repeat (3) @(posedge clk_100);
        #1;
        probe("reset", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        rst_100 = 1'b0;

        // nominal write, slave ACKs
        slave_ack = 1;
        issue(32'h78310311, 4, LAT4, 1'b0, 1'b1);
        wait_ack("wait_t1");

        // extra requests with new cfg_data mid-transaction are ignored
        issue(32'hA5C30F42, 4, LAT4, 1'b0, 1'b1);
        repeat (200) @(posedge clk_100);
        #1; cfg_data = 32'hFFFFFFFF; i2c_req = 1'b1;
        @(posedge clk_100); #1; i2c_req = 1'b0;
        repeat (100) @(posedge clk_100);
        #1; cfg_data = 32'h00000000; i2c_req = 1'b1;
        @(posedge clk_100); #1; i2c_req = 1'b0;
        wait_ack("wait_t2");
        repeat (40) @(posedge clk_100);

        // slave NACKs everything
        slave_ack = 0;
        issue(32'h42FF0180, NACK_NB, NACK_LAT, NACK_FLG, 1'b1);
        wait_ack("wait_t3");
        repeat (5) @(posedge clk_100);
        #1; probe("nack_sticky", 1'b1, 1'b1, 1'b0, 1'b0, NACK_FLG);
        slave_ack = 1;
        issue(32'h60010203, 4, LAT4, 1'b0, 1'b1);
        wait_ack("wait_t3b");

        // reset during byte 2 aborts silently, then a fresh write completes
        issue(32'h5A3C9966, 4, LAT4, 1'b0, 1'b0);
        repeat (360) @(posedge clk_100);
        #1; rst_100 = 1'b1;
        @(posedge clk_100); #1;
        probe("abort", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        rst_100 = 1'b0;
        repeat (20) @(posedge clk_100);
        issue(32'h21436587, 4, LAT4, 1'b0, 1'b1);
        wait_ack("wait_t4");

        // back-to-back: second request in the IDLE cycle right after i2c_ack
        issue(32'hC0FFEE01, 4, LAT4, 1'b0, 1'b1);
        wait_ack("wait_t5a");
        issue(32'h11223344, 4, LAT4, 1'b0, 1'b1);
        wait_ack("wait_t5b");

        repeat (30) @(posedge clk_100);
        pq.push_back('{"sb_drain", 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        repeat (3) @(negedge clk_100);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
